// File: rtl/conv_mac_accum.sv
// conv_mac_accum: multiply-accumulate stage behind the convolution loop controller.
// It takes one kernel-tap tuple per handshake and issues the image and weight
// reads for that tap. It then accumulates img*wgt over the taps of a pixel. On
// the last tap it adds the shifted bias, applies the output shift, the optional
// ReLU and int8 saturation, and holds the pixel until the consumer takes it.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   idx_valid/idx_ready        tap tuple handshake (i,j,k,m,n,l,in_row,in_col)
//   img_rd_en/img_addr         image read, data on img_data one cycle later
//   wgt_rd_en/wgt_addr         weight read, data on wgt_data one cycle later
//   bias_addr/bias_data        bias read (address = i), one-cycle latency
//   out_valid/out_ready        result handshake, out_data/out_addr held while stalled
module conv_mac_accum #(
  parameter int unsigned CONV_IM_DIM     = 32,
  parameter int unsigned CONV_IM_CH      = 3,
  parameter int unsigned CONV_DIM_KERNEL = 5,
  parameter int unsigned CONV_DIM_OUT    = 32,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned BIAS_SHIFT      = 0,
  parameter int unsigned OUT_SHIFT       = 9,
  parameter bit          RELU            = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idx_valid,
  output logic              idx_ready,
  input  logic [7:0]        i,
  input  logic [7:0]        j,
  input  logic [7:0]        k,
  input  logic [7:0]        m,
  input  logic [7:0]        n,
  input  logic [1:0]        l,
  input  logic [7:0]        in_row,
  input  logic [7:0]        in_col,
  output logic              img_rd_en,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_data,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_addr,
  input  logic [7:0]        wgt_data,
  output logic [7:0]        bias_addr,
  input  logic [7:0]        bias_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] out_addr
);

  localparam int unsigned K = CONV_DIM_KERNEL;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   idx_ready_q, idx_ready_d;
  logic   out_valid_q, out_valid_d;

  // E0 -> E1 pipeline stage
  logic              p1_valid_q, p1_valid_d;
  logic              p1_first_q, p1_first_d;
  logic              p1_last_q,  p1_last_d;
  logic              p1_inb_q,   p1_inb_d;
  logic [ADDR_W-1:0] p1_addr_q,  p1_addr_d;

  // E1 -> E2 pipeline stage
  logic              p2_valid_q, p2_valid_d;
  logic [ADDR_W-1:0] p2_addr_q,  p2_addr_d;

  logic signed [31:0] acc_q, acc_d;
  logic [7:0]         bias_q, bias_d;
  logic [7:0]         out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;

  logic               accept_c, in_bounds_c, first_c, last_c;
  logic signed [15:0] img_ext_c, wgt_ext_c, prod16_c;
  logic signed [31:0] product_c, bias_ext_c, sum_c, shifted_c;
  logic [7:0]         sat_c;

  // Tap decode, bounds test and memory addressing straight from the inputs
  always_comb begin
    accept_c    = idx_valid & idx_ready_q;
    // Negative coordinates are padding; the sign bit rejects them before the unsigned compare
    in_bounds_c = !in_row[7] && !in_col[7] &&
                  (32'(in_row) < CONV_IM_DIM) && (32'(in_col) < CONV_IM_DIM);
    first_c     = (m == 8'd0) && (n == 8'd0) && (l == 2'd0);
    last_c      = (32'(m) == K - 1) && (32'(n) == K - 1) && (32'(l) == CONV_IM_CH - 1);
    img_addr    = ADDR_W'((32'(in_row) * CONV_IM_DIM + 32'(in_col)) * CONV_IM_CH + 32'(l));
    wgt_addr    = ADDR_W'(((32'(i) * K + 32'(m)) * K + 32'(n)) * CONV_IM_CH + 32'(l));
    bias_addr   = i;
    img_rd_en   = accept_c & in_bounds_c;
    wgt_rd_en   = accept_c;
  end

  // Datapath: tap capture, multiply-accumulate, bias/shift/ReLU/saturate
  always_comb begin
    p1_valid_d = accept_c;
    p1_first_d = p1_first_q;
    p1_last_d  = p1_last_q;
    p1_inb_d   = p1_inb_q;
    p1_addr_d  = p1_addr_q;
    if (accept_c) begin
      p1_first_d = first_c;
      p1_last_d  = last_c;
      p1_inb_d   = in_bounds_c;
      p1_addr_d  = ADDR_W'((32'(i) * CONV_DIM_OUT + 32'(j)) * CONV_DIM_OUT + 32'(k));
    end

    img_ext_c = {{8{img_data[7]}}, img_data};
    wgt_ext_c = {{8{wgt_data[7]}}, wgt_data};
    prod16_c  = img_ext_c * wgt_ext_c;
    product_c = '0;
    if (p1_inb_q) begin
      product_c = {{16{prod16_c[15]}}, prod16_c};
    end

    // A first tap restarts the sum, so any unfinished pixel is dropped
    acc_d  = acc_q;
    bias_d = bias_q;
    if (p1_valid_q) begin
      acc_d = p1_first_q ? product_c : acc_q + product_c;
      if (p1_last_q) begin
        bias_d = bias_data;
      end
    end
    p2_valid_d = p1_valid_q & p1_last_q;
    p2_addr_d  = p1_valid_q ? p1_addr_q : p2_addr_q;

    bias_ext_c = {{24{bias_q[7]}}, bias_q};
    sum_c      = acc_q + (bias_ext_c <<< BIAS_SHIFT);
    shifted_c  = sum_c >>> OUT_SHIFT;
    if (RELU && shifted_c[31]) begin
      shifted_c = '0;
    end
    if (shifted_c > 32'sd127) begin
      sat_c = 8'h7F;
    end else if (shifted_c < -32'sd128) begin
      sat_c = 8'h80;
    end else begin
      sat_c = shifted_c[7:0];
    end

    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    if (p2_valid_q) begin
      out_data_d = sat_c;
      out_addr_d = p2_addr_q;
    end
  end

  // Control FSM: accept taps, wait for the finished pixel, hold it until taken
  always_comb begin
    state_d     = state_q;
    idx_ready_d = idx_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ACCUM: begin
        if (accept_c && last_c) begin
          state_d     = DRAIN;
          idx_ready_d = 1'b0;
        end
      end
      DRAIN: begin
        if (p2_valid_q) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          idx_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ACCUM;
        idx_ready_d = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      idx_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_first_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      p1_inb_q    <= 1'b0;
      p1_addr_q   <= '0;
      p2_valid_q  <= 1'b0;
      p2_addr_q   <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_ready_q <= idx_ready_d;
      out_valid_q <= out_valid_d;
      p1_valid_q  <= p1_valid_d;
      p1_first_q  <= p1_first_d;
      p1_last_q   <= p1_last_d;
      p1_inb_q    <= p1_inb_d;
      p1_addr_q   <= p1_addr_d;
      p2_valid_q  <= p2_valid_d;
      p2_addr_q   <= p2_addr_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign idx_ready = idx_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_conv_mac_accum.sv
// Directed bench for conv_mac_accum. Two instances share all stimulus:
// u_dut has a 3x3 kernel, 1 channel, no shifts and no ReLU. u_relu has the same
// geometry with bias<<1, output >>>2 and ReLU enabled.
module tb_conv_mac_accum;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        idx_valid = 1'b0;
  logic [7:0]  i_s = '0, j_s = '0, k_s = '0, m_s = '0, n_s = '0;
  logic [1:0]  l_s = '0;
  logic [7:0]  in_row = '0, in_col = '0;
  logic [7:0]  img_data = '0, wgt_data = '0, bias_data = '0;
  logic        out_ready = 1'b0;

  logic        idx_ready, img_rd_en, wgt_rd_en, out_valid;
  logic [15:0] img_addr, wgt_addr, out_addr;
  logic [7:0]  bias_addr, out_data;
  logic        r_idx_ready, r_img_rd_en, r_wgt_rd_en, r_out_valid;
  logic [15:0] r_img_addr, r_wgt_addr, r_out_addr;
  logic [7:0]  r_bias_addr, r_out_data;

  logic [7:0]  cur_img = '0, cur_wgt = '0;
  logic [7:0]  img_v [9];
  logic [7:0]  wgt_v [9];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // One-cycle-latency memories; unread cycles return junk so padded taps must be zeroed
  always @(posedge clk) begin
    img_data <= img_rd_en ? cur_img : 8'h55;
    wgt_data <= wgt_rd_en ? cur_wgt : 8'h55;
  end

  conv_mac_accum #(.CONV_IM_DIM(32), .CONV_IM_CH(1), .CONV_DIM_KERNEL(3), .CONV_DIM_OUT(32),
                   .ADDR_W(16), .BIAS_SHIFT(0), .OUT_SHIFT(0), .RELU(1'b0)) u_dut (
    .clk(clk), .reset(reset), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .i(i_s), .j(j_s), .k(k_s), .m(m_s), .n(n_s), .l(l_s), .in_row(in_row), .in_col(in_col),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_data(img_data),
    .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .bias_addr(bias_addr), .bias_data(bias_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  conv_mac_accum #(.CONV_IM_DIM(32), .CONV_IM_CH(1), .CONV_DIM_KERNEL(3), .CONV_DIM_OUT(32),
                   .ADDR_W(16), .BIAS_SHIFT(1), .OUT_SHIFT(2), .RELU(1'b1)) u_relu (
    .clk(clk), .reset(reset), .idx_valid(idx_valid), .idx_ready(r_idx_ready),
    .i(i_s), .j(j_s), .k(k_s), .m(m_s), .n(n_s), .l(l_s), .in_row(in_row), .in_col(in_col),
    .img_rd_en(r_img_rd_en), .img_addr(r_img_addr), .img_data(img_data),
    .wgt_rd_en(r_wgt_rd_en), .wgt_addr(r_wgt_addr), .wgt_data(wgt_data),
    .bias_addr(r_bias_addr), .bias_data(bias_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data), .out_addr(r_out_addr)
  );

  // Present one tap from a negedge and return at the negedge after its accept edge
  task automatic send_tap(input logic [7:0] ti, tj, tk, tm, tn, input int row, col,
                          input logic [7:0] im, wg, output int waited);
    logic exp_rd;
    i_s = ti; j_s = tj; k_s = tk; m_s = tm; n_s = tn; l_s = 2'd0;
    in_row = 8'(row); in_col = 8'(col);
    cur_img = im; cur_wgt = wg;
    idx_valid = 1'b1;
    waited = 0;
    while (idx_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    exp_rd = (row >= 0) && (row < 32) && (col >= 0) && (col < 32);
    checks++;
    if (img_rd_en !== exp_rd || waited >= 20)
      $display("FAIL tap_rd_en m=%0d n=%0d: got %b waited %0d, expected %b", tm, tn, img_rd_en, waited, exp_rd);
    if (img_rd_en !== exp_rd || waited >= 20) errors++;
    @(negedge clk);
  endtask

  // Nine back-to-back taps of a 3x3 pixel using img_v/wgt_v
  task automatic send_pixel(input logic [7:0] ti, tj, tk, input int row0, col0, output int stall);
    int w;
    stall = 0;
    for (int t = 0; t < 9; t++) begin
      send_tap(ti, tj, tk, 8'(t / 3), 8'(t % 3), row0 + t / 3, col0 + t % 3, img_v[t], wgt_v[t], w);
      stall += w;
    end
    idx_valid = 1'b0;
  endtask

  // Count negedges from the last accept until out_valid, bounded
  task automatic await_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic fill(input logic [7:0] im, wg);
    for (int t = 0; t < 9; t++) begin
      img_v[t] = im;
      wgt_v[t] = wg;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (idx_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 || out_addr !== 16'd0 ||
        img_rd_en !== 1'b0 || wgt_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b ov=%b od=%h oa=%h ird=%b wrd=%b, expected 1 0 00 0000 0 0",
               idx_ready, out_valid, out_data, out_addr, img_rd_en, wgt_rd_en);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr;
    i_s = 8'd1; j_s = 8'd0; k_s = 8'd0; m_s = 8'd2; n_s = 8'd1; l_s = 2'd0;
    in_row = 8'd4; in_col = 8'd5;
    #1;
    checks++;
    if (img_rd_en !== 1'b0 || wgt_rd_en !== 1'b0) begin
      errors++; $display("FAIL strobe_idle: img %b wgt %b, expected 0 0", img_rd_en, wgt_rd_en);
    end
    idx_valid = 1'b1;
    #1;
    checks++;
    if (img_rd_en !== 1'b1 || wgt_rd_en !== 1'b1 || img_addr !== 16'd133 || wgt_addr !== 16'd16 ||
        bias_addr !== 8'd1) begin
      errors++;
      $display("FAIL addr_inb: rd %b/%b img %0d wgt %0d bias %0d, expected 1/1 133 16 1",
               img_rd_en, wgt_rd_en, img_addr, wgt_addr, bias_addr);
    end
    checks++;
    if (r_img_rd_en !== 1'b1 || r_wgt_rd_en !== 1'b1 || r_img_addr !== 16'd133 ||
        r_wgt_addr !== 16'd16 || r_bias_addr !== 8'd1) begin
      errors++; $display("FAIL addr_relu_inst: img %0d wgt %0d, expected 133 16", r_img_addr, r_wgt_addr);
    end
    in_row = 8'hFF;
    #1;
    checks++;
    if (img_rd_en !== 1'b0) begin
      errors++; $display("FAIL pad_row_neg: img_rd_en %b, expected 0", img_rd_en);
    end
    in_row = 8'd31; in_col = 8'd31;
    #1;
    checks++;
    if (img_rd_en !== 1'b1 || img_addr !== 16'd1023) begin
      errors++; $display("FAIL corner_31_31: rd %b addr %0d, expected 1 1023", img_rd_en, img_addr);
    end
    in_col = 8'd32;
    #1;
    checks++;
    if (img_rd_en !== 1'b0) begin
      errors++; $display("FAIL pad_col_32: img_rd_en %b, expected 0", img_rd_en);
    end
    idx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int stall, lat;
    fill(8'd1, 8'd2);
    bias_data = 8'd5;
    send_pixel(8'd1, 8'd2, 8'd3, 1, 2, stall);
    checks++;
    if (stall !== 0 || idx_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: stall %0d rdy %b ov %b, expected 0 0 0", stall, idx_ready, out_valid);
    end
    await_result(lat);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL basic_latency: %0d, expected 2", lat);
    end
    checks++;
    if (out_data !== 8'd23 || out_addr !== 16'd1091 || idx_ready !== 1'b0) begin
      errors++; $display("FAIL basic_result: data %0d addr %0d rdy %b, expected 23 1091 0", out_data, out_addr, idx_ready);
    end
    checks++;
    if (r_out_valid !== 1'b1 || r_out_data !== 8'd7 || r_out_addr !== 16'd1091) begin
      errors++; $display("FAIL basic_shifted: v %b data %0d addr %0d, expected 1 7 1091", r_out_valid, r_out_data, r_out_addr);
    end
    release_result();
    checks++;
    if (out_valid !== 1'b0 || idx_ready !== 1'b1 || r_idx_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release: ov %b rdy %b, expected 0 1", out_valid, idx_ready);
    end
  endtask

  task automatic test_saturation;
    int stall, lat;
    fill(8'd1, 8'd100);
    bias_data = 8'd0;
    send_pixel(8'd2, 8'd0, 8'd5, 0, 0, stall);
    await_result(lat);
    checks++;
    if (lat !== 2 || out_data !== 8'h7F || r_out_data !== 8'h7F || out_addr !== 16'd2053) begin
      errors++; $display("FAIL sat_pos: lat %0d data %h/%h addr %0d, expected 2 7f/7f 2053", lat, out_data, r_out_data, out_addr);
    end
    release_result();
    fill(8'h9C, 8'd100);
    send_pixel(8'd0, 8'd31, 8'd31, 0, 0, stall);
    await_result(lat);
    checks++;
    if (lat !== 2 || out_data !== 8'h80 || r_out_data !== 8'h00 || out_addr !== 16'd1023) begin
      errors++; $display("FAIL sat_neg: lat %0d data %h/%h addr %0d, expected 2 80/00 1023", lat, out_data, r_out_data, out_addr);
    end
    release_result();
  endtask

  task automatic test_relu;
    int stall, lat;
    fill(8'd0, 8'd7);
    img_v[0] = 8'hFB;
    bias_data = 8'd3;
    send_pixel(8'd0, 8'd1, 8'd1, 0, 0, stall);
    await_result(lat);
    checks++;
    if (lat !== 2 || out_data !== 8'hE0 || r_out_data !== 8'h00 || out_addr !== 16'd33) begin
      errors++; $display("FAIL relu_neg: lat %0d data %h/%h addr %0d, expected 2 e0/00 33", lat, out_data, r_out_data, out_addr);
    end
    release_result();
  endtask

  task automatic test_padding;
    int stall, lat;
    fill(8'd1, 8'd1);
    bias_data = 8'd0;
    send_pixel(8'd0, 8'd0, 8'd1, -1, 0, stall);
    await_result(lat);
    checks++;
    if (lat !== 2 || out_data !== 8'd6 || r_out_data !== 8'd1 || out_addr !== 16'd1) begin
      errors++; $display("FAIL padding: lat %0d data %0d/%0d addr %0d, expected 2 6/1 1", lat, out_data, r_out_data, out_addr);
    end
    release_result();
  endtask

  task automatic test_backpressure;
    int stall, lat;
    fill(8'd1, 8'd3);
    bias_data = 8'hFE;
    send_pixel(8'd3, 8'd4, 8'd5, 0, 0, stall);
    await_result(lat);
    checks++;
    if (lat !== 2 || out_data !== 8'd25 || r_out_data !== 8'd5 || out_addr !== 16'd3205) begin
      errors++; $display("FAIL bp_result: lat %0d data %0d/%0d addr %0d, expected 2 25/5 3205", lat, out_data, r_out_data, out_addr);
    end
    i_s = 8'd0; j_s = 8'd0; k_s = 8'd2; m_s = 8'd0; n_s = 8'd0; l_s = 2'd0;
    in_row = 8'd0; in_col = 8'd0;
    idx_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'd25 || out_addr !== 16'd3205 || idx_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: ov %b data %0d addr %0d rdy %b, expected 1 25 3205 0",
                 c, out_valid, out_data, out_addr, idx_ready);
      end
    end
    release_result();
    checks++;
    if (idx_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: rdy %b ov %b, expected 1 0", idx_ready, out_valid);
    end
    fill(8'd2, 8'd2);
    bias_data = 8'd0;
    send_pixel(8'd0, 8'd0, 8'd2, 0, 0, stall);
    checks++;
    if (stall !== 0) begin
      errors++; $display("FAIL bp_resume_stall: %0d, expected 0", stall);
    end
    await_result(lat);
    checks++;
    if (lat !== 2 || out_data !== 8'd36 || r_out_data !== 8'd9 || out_addr !== 16'd2) begin
      errors++; $display("FAIL bp_next: lat %0d data %0d/%0d addr %0d, expected 2 36/9 2", lat, out_data, r_out_data, out_addr);
    end
    release_result();
  endtask

  task automatic test_reset_mid;
    int w, stall, lat, seen;
    for (int t = 0; t < 5; t++)
      send_tap(8'd1, 8'd2, 8'd3, 8'(t / 3), 8'(t % 3), t / 3, t % 3, 8'd9, 8'd9, w);
    idx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (idx_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 || out_addr !== 16'd0) begin
      errors++; $display("FAIL mid_reset_values: rdy %b ov %b od %0d oa %0d, expected 1 0 0 0",
                         idx_ready, out_valid, out_data, out_addr);
    end
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid === 1'b1 || r_out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL mid_stale_output: %0d valid cycles, expected 0", seen);
    end
    fill(8'd2, 8'd3);
    bias_data = 8'd1;
    send_pixel(8'd1, 8'd2, 8'd3, 0, 0, stall);
    await_result(lat);
    checks++;
    if (lat !== 2 || out_data !== 8'd55 || r_out_data !== 8'd14 || out_addr !== 16'd1091) begin
      errors++; $display("FAIL mid_new_pixel: lat %0d data %0d/%0d addr %0d, expected 2 55/14 1091", lat, out_data, r_out_data, out_addr);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_addr();
    test_basic();
    test_saturation();
    test_relu();
    test_padding();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
